// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the digit-serial adder.
//   - state_e      : operand framing FSM states
//   - digit_cnt_w  : width of the digit index for a given digit count
// Optional feature macro used by the design: SERIAL_ADDER_SUB_EN
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // next accepted beat is digit 0 of a new operand
    ST_ACCUM = 1'b1   // partial operand in flight
  } state_e;

  // Digit index width; callers guarantee num_digits >= 2, so this is >= 1.
  function automatic int digit_cnt_w(input int num_digits);
    return $clog2(num_digits);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/digit_add_cell.sv
// -----------------------------------------------------------------------------
// digit_add_cell
//   Combinational DIGIT_W-bit adder slice with carry in/out and optional
//   inversion of operand b (used for A + ~B + 1 subtraction).
// Ports:
//   a, b      in   DIGIT_W  operand digits
//   cin       in   1        carry in
//   invert_b  in   1        1: add ~b instead of b
//   sum       out  DIGIT_W  sum digit
//   cout      out  1        carry out
// -----------------------------------------------------------------------------
module digit_add_cell #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  input  logic               invert_b,
  output logic [DIGIT_W-1:0] sum,
  output logic               cout
);

  logic [DIGIT_W-1:0] b_eff;
  logic [DIGIT_W:0]   total;

  // Full DIGIT_W+1 result so the carry is never truncated.
  assign b_eff = invert_b ? ~b : b;
  assign total = {1'b0, a} + {1'b0, b_eff} + {{DIGIT_W{1'b0}}, cin};
  assign sum   = total[DIGIT_W-1:0];
  assign cout  = total[DIGIT_W];

endmodule : digit_add_cell

// File: rtl/serial_digit_adder.sv
// -----------------------------------------------------------------------------
// serial_digit_adder
//   Adds two wide operands delivered one DIGIT_W-bit digit per beat, LSB digit
//   first. Carry is chained across the NUM_DIGITS beats of one operand pair.
//   One registered sum digit is emitted per accepted beat (latency 1); the
//   final carry is presented with the last digit.
// Parameters:
//   DIGIT_W     bits per digit (>=1)
//   NUM_DIGITS  digits per operand (>=2)
// Ports:
//   clock      in   1        rising-edge clock
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        in_a/in_b digit present
//   in_ready   out  1        digit can be accepted this cycle
//   in_a       in   DIGIT_W  operand A digit
//   in_b       in   DIGIT_W  operand B digit
//   in_sub     in   1        (SERIAL_ADDER_SUB_EN only) subtract, sampled on digit 0
//   out_valid  out  1        out_sum valid
//   out_ready  in   1        downstream accepts out_sum
//   out_sum    out  DIGIT_W  sum digit, LSB digit first
//   out_last   out  1        out_sum is the last digit of the operand
//   out_carry  out  1        final carry (no-borrow when subtracting), 0 unless out_last
//   busy       out  1        partial operand in flight
// Optional feature: define SERIAL_ADDER_SUB_EN to add in_sub and A-B support.
// -----------------------------------------------------------------------------
module serial_digit_adder #(
  parameter int DIGIT_W    = 4,
  parameter int NUM_DIGITS = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] in_a,
  input  logic [DIGIT_W-1:0] in_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic               in_sub,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_sum,
  output logic               out_last,
  output logic               out_carry,
  output logic               busy
);

  import serial_adder_pkg::*;

  localparam int               CNT_W    = digit_cnt_w(NUM_DIGITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               out_valid_q, out_valid_d;
  logic [DIGIT_W-1:0] out_sum_q, out_sum_d;
  logic               out_last_q, out_last_d;
  logic               out_carry_q, out_carry_d;

  logic               accept;
  logic               is_first;
  logic               is_last;
  logic               cur_sub;
  logic               cell_cin;
  logic [DIGIT_W-1:0] cell_sum;
  logic               cell_cout;

  // One-entry output register: a new digit may enter whenever the slot is
  // empty or is being drained this very cycle, so there is no bubble.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign is_first = (state_q == ST_IDLE);
  assign is_last  = (idx_q == LAST_IDX);

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q, sub_d;

  // The operation is chosen by digit 0 and then locked for the operand.
  assign cur_sub = is_first ? in_sub : sub_q;
`else
  assign cur_sub = 1'b0;
`endif

  // Subtraction is A + ~B + 1: the +1 enters as the digit-0 carry in.
  assign cell_cin = is_first ? cur_sub : carry_q;

  digit_add_cell #(
    .DIGIT_W (DIGIT_W)
  ) u_cell (
    .a        (in_a),
    .b        (in_b),
    .cin      (cell_cin),
    .invert_b (cur_sub),
    .sum      (cell_sum),
    .cout     (cell_cout)
  );

  // Framing FSM: IDLE means the next beat is digit 0.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ACCUM;
      ST_ACCUM: if (accept && is_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath next state: digit index, carry chain and output register.
  always_comb begin
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_last_d  = out_last_q;
    out_carry_d = out_carry_q;
`ifdef SERIAL_ADDER_SUB_EN
    sub_d       = sub_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = cell_sum;
      out_last_d  = is_last;
      out_carry_d = is_last && cell_cout;
`ifdef SERIAL_ADDER_SUB_EN
      sub_d       = cur_sub;
`endif
      if (is_last) begin
        // Operand complete: the next beat starts fresh with no stale carry.
        idx_d   = '0;
        carry_d = 1'b0;
      end else begin
        idx_d   = idx_q + CNT_W'(1);
        carry_d = cell_cout;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_last_q  <= 1'b0;
      out_carry_q <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_last_q  <= out_last_d;
      out_carry_q <= out_carry_d;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_last  = out_last_q;
  assign out_carry = out_carry_q;
  assign busy      = (idx_q != '0);

endmodule : serial_digit_adder

// File: tb/tb_serial_digit_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_digit_adder
//   Scoreboard bench: each issued operand pair pushes its expected digits,
//   computed from whole-operand arithmetic, into a queue; a monitor pops and
//   compares on every output handshake.
//   Define SERIAL_ADDER_SUB_EN to also exercise subtraction.
// -----------------------------------------------------------------------------
module tb_serial_digit_adder;

  localparam int W    = 4;
  localparam int N    = 4;
  localparam int OP_W = W * N;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         last;
    logic         carry;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_carry;
  logic         busy;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   rand_bp = 1'b0;

  always #5 clock = ~clock;

  serial_digit_adder #(
    .DIGIT_W    (W),
    .NUM_DIGITS (N)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
`ifdef SERIAL_ADDER_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_carry (out_carry),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: whole-operand arithmetic, then split into digits.
  function automatic void push_expected(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                        input logic sub, input int ndig);
    logic [OP_W:0] total;
    exp_t          e;
    if (sub) begin
      total[OP_W-1:0] = a - b;
      total[OP_W]     = (a >= b);
    end else begin
      total = {1'b0, a} + {1'b0, b};
    end
    for (int d = 0; d < ndig; d++) begin
      e.sum   = total[d*W +: W];
      e.last  = (d == N - 1);
      e.carry = (d == N - 1) ? total[OP_W] : 1'b0;
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: compare every output handshake against the scoreboard.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(out_sum), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_last", 32'(out_last), 32'(e.last));
        check("out_carry", 32'(out_carry), 32'(e.carry));
      end
    end
  end

  // Random backpressure, enabled only during the random phase.
  always @(posedge clock) begin
    if (rand_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present one digit and hold it until accepted (bounded wait).
  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    @(negedge clock);
    while (!in_ready && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_operand(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                              input logic sub, input int max_gap);
    push_expected(a, b, sub, N);
    for (int d = 0; d < N; d++) begin
      if (max_gap > 0) idle_cycles($urandom_range(0, max_gap));
      drive_beat(a[d*W +: W], b[d*W +: W], sub);
    end
  endtask

  task automatic drain();
    int guard = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(posedge clock);
      #1;
      guard++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_carry", 32'(out_carry), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock);
    #1 reset = 1'b0;

    // Basic example and overflow.
    send_operand(16'h0F35, 16'hACF0, 1'b0, 0);
    send_operand(16'hFFFF, 16'h0001, 1'b0, 0);
    drain();

    // Backpressure while digit 1 (sum 2) is presented.
    push_expected(16'h0F35, 16'hACF0, 1'b0, N);
    drive_beat(4'h5, 4'h0, 1'b0);
    drive_beat(4'h3, 4'hF, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 4'hF;
    in_b      = 4'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_sum", 32'(out_sum), 32'h2);
      check("stall_busy", 32'(busy), 32'd1);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    drive_beat(4'hF, 4'hC, 1'b0);
    drive_beat(4'h0, 4'hA, 1'b0);
    drain();

    // Reset after two digits of 0xFFFF + 0x0001; no stale carry afterwards.
    push_expected(16'hFFFF, 16'h0001, 1'b0, 2);
    drive_beat(4'hF, 4'h1, 1'b0);
    drive_beat(4'hF, 4'h0, 1'b0);
    @(negedge clock);
    check("mid_busy", 32'(busy), 32'd1);
    @(posedge clock);
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    send_operand(16'h0001, 16'h0001, 1'b0, 0);
    drain();

    // Two operands back-to-back: 8 consecutive valid output cycles.
    fork
      begin
        send_operand(16'hFFFF, 16'h0001, 1'b0, 0);
        send_operand(16'h1234, 16'h4321, 1'b0, 0);
      end
      begin
        int guard = 0;
        int run   = 0;
        @(negedge clock);
        while (!out_valid && guard < 20) begin
          @(negedge clock);
          guard++;
        end
        for (int i = 0; i < 8; i++) begin
          if (out_valid) run++;
          @(negedge clock);
        end
        check("b2b_valid_run", 32'(run), 32'd8);
      end
    join
    drain();

`ifdef SERIAL_ADDER_SUB_EN
    send_operand(16'h0F35, 16'hACF0, 1'b1, 0);
    send_operand(16'hACF0, 16'h0F35, 1'b1, 0);
    send_operand(16'h1234, 16'h1234, 1'b1, 0);
    drain();
`endif

    // Randomized operands, gaps and backpressure.
    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      logic [OP_W-1:0] a;
      logic [OP_W-1:0] b;
      logic            sub;
      a = OP_W'($urandom);
      b = OP_W'($urandom);
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '1;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      send_operand(a, b, sub, 2);
    end
    rand_bp = 1'b0;
    @(posedge clock);
    #2 out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_serial_digit_adder
